// File: rtl/demux_router_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// demux_pkg : shared widths and channel-select encoding for demux_router
// Rev 1.0
// ---------------------------------------------------------------------------
package demux_pkg;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 8;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } ch_sel_e;

  typedef logic [DATA_W-1:0] data_t;

endpackage
`default_nettype wire

// File: rtl/demux_router_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// demux_router_if : input handshake plus two output channels (DEMUX_CNT_EN adds cnt0/cnt1)
// Rev 1.0
// ---------------------------------------------------------------------------
interface demux_router_if;
  import demux_pkg::*;

  data_t in_data;
  logic  in_valid;
  logic  in_sel;
  logic  in_ready;

  data_t out0_data;
  logic  out0_valid;
  logic  out0_ready;
  data_t out1_data;
  logic  out1_valid;
  logic  out1_ready;

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
`endif

  modport slave (
    input  in_data, in_valid, in_sel, out0_ready, out1_ready,
`ifdef DEMUX_CNT_EN
    output cnt0, cnt1,
`endif
    output in_ready, out0_data, out0_valid, out1_data, out1_valid
  );

  modport master (
    output in_data, in_valid, in_sel, out0_ready, out1_ready,
`ifdef DEMUX_CNT_EN
    input  cnt0, cnt1,
`endif
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid
  );

endinterface
`default_nettype wire

// File: rtl/demux_router_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// demux_buf : DEPTH-entry per-channel FIFO; head word held after drain, zero after reset
// Rev 1.0
// ---------------------------------------------------------------------------
module demux_buf
  import demux_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push_i,
  input  data_t data_i,
  input  logic  pop_i,
  output data_t data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  data_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  data_t            last_q, last_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (occ_q == OCC_W'(DEPTH));
  assign empty_o = (occ_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // last_q keeps the most recently popped word so an empty channel shows it
  assign data_o  = empty_o ? last_q : mem_q[rd_q];

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    occ_d  = occ_q;
    last_d = last_q;
    if (do_push) begin
      wr_d = wr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_d   = rd_q + PTR_W'(1);
      last_d = mem_q[rd_q];
    end
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      occ_q  <= '0;
      last_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      occ_q  <= occ_d;
      last_q <= last_d;
      if (do_push) begin
        mem_q[wr_q] <= data_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/demux_router.sv
`default_nettype none
// ---------------------------------------------------------------------------
// demux_router : 1-to-2 buffered demux; DEMUX_CNT_EN adds per-channel delivery counters
// Rev 1.0
// ---------------------------------------------------------------------------
module demux_router
  import demux_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  demux_router_if.slave  bus
);

  logic  full0, full1;
  logic  empty0, empty1;
  logic  push0, push1;
  logic  pop0, pop1;
  logic  sel_ch1;
  data_t data0, data1;

  assign sel_ch1 = (ch_sel_e'(bus.in_sel) == CH1);

  // Readiness looks only at the selected channel's occupancy, never at a pop
  assign bus.in_ready = sel_ch1 ? !full1 : !full0;

  assign push0 = bus.in_valid && !sel_ch1 && !full0;
  assign push1 = bus.in_valid &&  sel_ch1 && !full1;

  assign bus.out0_valid = !empty0;
  assign bus.out1_valid = !empty1;
  assign bus.out0_data  = data0;
  assign bus.out1_data  = data1;
  assign pop0 = !empty0 && bus.out0_ready;
  assign pop1 = !empty1 && bus.out1_ready;

  demux_buf #(.DEPTH(DEPTH)) u_buf0 (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push0),
    .data_i  (bus.in_data),
    .pop_i   (pop0),
    .data_o  (data0),
    .full_o  (full0),
    .empty_o (empty0)
  );

  demux_buf #(.DEPTH(DEPTH)) u_buf1 (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push1),
    .data_i  (bus.in_data),
    .pop_i   (pop1),
    .data_o  (data1),
    .full_o  (full1),
    .empty_o (empty1)
  );

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (pop0) cnt0_q <= cnt0_q + CNT_W'(1);
      if (pop1) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;
`endif

endmodule
`default_nettype wire

// File: doc/demux_router.md
DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: in_data  input  4  input word.
REQ-004 SHALL have port: in_valid  input  1  in_data/in_sel valid this cycle.
REQ-005 SHALL have port: in_sel  input  1  destination channel: 0 = ch0, 1 = ch1.
REQ-006 SHALL have port: in_ready  output  1  selected channel can accept.
REQ-007 SHALL have ports: out0_data / out1_data  output  4  head word of channel buffer.
REQ-008 SHALL have ports: out0_valid / out1_valid  output  1  channel buffer non-empty.
REQ-009 SHALL have ports: out0_ready / out1_ready  input  1  consumer accepts head word.
REQ-010 SHALL have ports (DEMUX_CNT_EN only): cnt0 / cnt1  output  8  words delivered per channel.
REQ-011 SHALL have parameter: DEPTH, default 2, entries per channel buffer (power of two, >= 2).

Function
REQ-012 Input transfer SHALL occur when in_valid && in_ready at a clk edge; the word goes to the channel selected by in_sel.
REQ-013 Output transfer on channel k SHALL occur when outk_valid && outk_ready at a clk edge; the head word is popped.
REQ-014 in_ready SHALL be 1 exactly when the channel selected by in_sel holds fewer than DEPTH words; it SHALL NOT depend on any outk_ready.
REQ-015 Latency SHALL be 1 cycle: a word accepted at edge N appears on outk_data with outk_valid=1 after edge N if the buffer was empty.
REQ-016 Per-channel order SHALL be preserved; there SHALL be no ordering requirement between channels.
REQ-017 The non-selected channel SHALL NOT change occupancy except by its own pop.
REQ-018 Full: when the selected channel holds DEPTH words, in_ready=0 and no word SHALL be written, even if that channel pops in the same cycle.
REQ-019 Simultaneous push and pop on the same non-full channel SHALL leave occupancy unchanged and advance the head.
REQ-020 Empty: outk_valid=0; outk_data SHALL hold its last value, or 4'b0000 after reset.
REQ-021 Read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH.
REQ-022 in_sel, in_data and in_valid are SHALL-be-ignored when in_valid=0.

Reset
REQ-023 With rst=1 at a clk edge, every channel buffer SHALL be emptied: out0_valid=out1_valid=0, out0_data=out1_data=4'b0000, in_ready=1.
REQ-024 Reset mid-operation SHALL discard all buffered words; no transfer SHALL be counted in the reset cycle.
REQ-025 With DEMUX_CNT_EN, rst SHALL clear cnt0 and cnt1 to 8'd0.

Configuration
REQ-026 Macro DEMUX_CNT_EN defined: cnt0/cnt1 ports exist, increment by 1 per output transfer on their channel, and wrap 255 -> 0.
REQ-027 Macro DEMUX_CNT_EN undefined: cnt0/cnt1 ports and counter logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Shared package demux_pkg SHALL hold the data width constant (4), the channel-select encoding (CH0=1'b0, CH1=1'b1), and the counter width (8).
REQ-029 The per-channel buffer SHALL be a sub-module demux_buf (push/pop, data, full, empty), instantiated twice.

Verification
REQ-030 Reset, then push 4'hA with in_sel=0, out0_ready=1 -> out0_valid=1, out0_data=4'hA one cycle later; out1_valid stays 0.
REQ-031 out1_ready=0, push 4'h1, 4'h2 to ch1 -> in_ready=0 with in_sel=1, in_ready=1 with in_sel=0; a third ch1 word is not accepted.
REQ-032 ch1 full, assert out1_ready and in_valid with in_sel=1 in the same cycle -> one pop of 4'h1, no push; occupancy becomes 1.
REQ-033 Interleave 4'h3->ch0, 4'h4->ch1, 4'h5->ch0, both readies 1 -> ch0 delivers 3 then 5, ch1 delivers 4.
REQ-034 Fill ch0 with 2 words, assert rst for one cycle -> both outk_valid=0, outk_data=4'h0, in_ready=1.
REQ-035 DEMUX_CNT_EN defined: 256 ch0 deliveries -> cnt0 returns to 8'd0; cnt1 stays 8'd0.
